// File: rtl/imem_if.sv
// Fetch <-> instruction-memory request/response link.
interface imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency reads, in-order response FIFO,
// credit-based request throttling, flush on branch-taken, program-load write port.
module imem_responder #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  imem_if.slave       bus,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef logic [MEM_WORDS-1:0][31:0] mem_t;

  // Power-up image: every word holds its own index.
  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < MEM_WORDS; i++) m[i] = 32'(i);
    return m;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  mem_t             mem_q = mem_init();
  ent_t             pipe_q [PIPE_N];
  ent_t             pipe_d [PIPE_N];
  ent_t             fifo_q [RSP_DEPTH];
  ent_t             fifo_d [RSP_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_q, out_d;
  logic             accept, pop, push, req_bad, wr_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  ent_t             new_ent, push_ent;
  logic             unused_bits;

  // Pop frees a credit in the same cycle, so a full responder can still accept.
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.req_ready = !rst && !flush && ((out_q < CNT_W'(RSP_DEPTH)) || pop);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (cnt_q != '0);
  assign bus.rsp_data  = fifo_q[rd_ptr_q].data;
  assign bus.rsp_addr  = fifo_q[rd_ptr_q].addr;
  assign bus.rsp_err   = fifo_q[rd_ptr_q].err;
  assign unused_bits   = ^{wr_addr[1:0], fifo_q[rd_ptr_q].vld};

  // Decode the request and read memory at acceptance (read-before-write).
  always_comb begin
    rd_idx       = bus.req_addr[IDX_W+1:2];
    req_bad      = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:IDX_W+2] != '0);
    new_ent.vld  = accept;
    new_ent.err  = req_bad;
    new_ent.addr = bus.req_addr;
    new_ent.data = req_bad ? 32'h0 : mem_q[rd_idx];
    push_ent     = (LATENCY == 1) ? new_ent : pipe_q[PIPE_N-1];
    push         = push_ent.vld;
    wr_idx       = wr_addr[IDX_W+1:2];
    wr_ok        = (wr_addr[31:IDX_W+2] == '0);
  end

  // Next state: latency pipeline, response FIFO, outstanding credit count.
  always_comb begin
    pipe_d   = pipe_q;
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    if (flush) begin
      for (int unsigned i = 0; i < PIPE_N; i++) pipe_d[i].vld = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      out_d    = '0;
    end else begin
      pipe_d[0] = new_ent;
      for (int unsigned i = 1; i < PIPE_N; i++) pipe_d[i] = pipe_q[i-1];
      if (push) begin
        fifo_d[wr_ptr_q] = push_ent;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      out_d = out_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      pipe_q   <= pipe_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  // Program-load write; memory survives reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en && wr_ok) mem_q[wr_idx] <= wr_data;
  end
endmodule
